// File: rtl/uart_rx_queue.sv
// uart_rx_queue: 8N1 UART receiver feeding an 8-entry circular byte queue.
// The CPU pops the head byte by reading I/O address 0; occupancy and
// overrun/framing status are exported to the peripheral wrapper.
module uart_rx_queue (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       iocs_n,
    input  logic       iorw_n,
    input  logic [1:0] ioaddr,
    input  logic [4:0] DBH,
    input  logic [7:0] DBL,
    output logic [7:0] rx_data,
    output logic       rx_queue_empty,
    output logic       rx_queue_full,
    output logic [3:0] rx_num_available,
    output logic       rx_overrun,
    output logic       frm_err
);

    localparam int unsigned DIV_W  = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned BCNT_W = 4;
    localparam int unsigned DEPTH  = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic              rx_meta_q;
    logic              rx_sync_q;
    logic [1:0]        state_q,     state_d;
    logic [DIV_W-1:0]  baud_cnt_q,  baud_cnt_d;
    logic [BCNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shift_reg_q, shift_reg_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              frm_err_q,    frm_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DIV_W-1:0]  div;
    logic [PTR_W-1:0]  count;
    logic              tick;
    logic              push;
    logic              pop;

    assign div   = {DBH, DBL};
    assign tick  = (baud_cnt_q == '0);
    assign count = wr_ptr_q - rd_ptr_q;

    assign rx_num_available = count;
    assign rx_queue_full    = (count == 4'd8);
    assign rx_queue_empty   = (count == 4'd0);
    assign rx_data          = mem_q[rd_ptr_q[2:0]];
    assign rx_overrun       = rx_overrun_q;
    assign frm_err          = frm_err_q;

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM next-state: baud timing, bit sampling and push/error decisions.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_reg_d  = shift_reg_q;
        push         = 1'b0;
        rx_overrun_d = 1'b0;
        frm_err_d    = 1'b0;

        if (state_q != IDLE && !tick) begin
            baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    baud_cnt_d = div >> 1;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_sync_q) begin
                        baud_cnt_d = div;
                        bit_cnt_d  = '0;
                        state_d    = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_reg_d = {rx_sync_q, shift_reg_q[DATA_W-1:1]};
                    baud_cnt_d  = div;
                    bit_cnt_d   = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(7)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        if (rx_queue_full) begin
                            rx_overrun_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        frm_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue pointer next-state; fullness is judged before a same-cycle pop.
    always_comb begin
        pop      = !iocs_n && iorw_n && (ioaddr == 2'b00) && !rx_queue_empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rx_overrun_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rx_overrun_q <= rx_overrun_d;
            frm_err_q    <= frm_err_d;
        end
    end

    // Queue storage; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[2:0]] <= shift_reg_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_queue.sv
// Directed bench for uart_rx_queue: frames are bit-banged on RX with a
// known divisor and queue state/status pulses are checked against
// hand-computed values.
module tb_uart_rx_queue;

    logic       clk;
    logic       rst;
    logic       RX;
    logic       iocs_n;
    logic       iorw_n;
    logic [1:0] ioaddr;
    logic [4:0] DBH;
    logic [7:0] DBL;
    logic [7:0] rx_data;
    logic       rx_queue_empty;
    logic       rx_queue_full;
    logic [3:0] rx_num_available;
    logic       rx_overrun;
    logic       frm_err;

    int n_checks;
    int n_fail;
    int ovr_cycles;
    int frm_cycles;
    int max_cnt;

    uart_rx_queue dut (
        .clk              (clk),
        .rst              (rst),
        .RX               (RX),
        .iocs_n           (iocs_n),
        .iorw_n           (iorw_n),
        .ioaddr           (ioaddr),
        .DBH              (DBH),
        .DBL              (DBL),
        .rx_data          (rx_data),
        .rx_queue_empty   (rx_queue_empty),
        .rx_queue_full    (rx_queue_full),
        .rx_num_available (rx_num_available),
        .rx_overrun       (rx_overrun),
        .frm_err          (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count status pulse cycles and peak occupancy, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_overrun) ovr_cycles++;
        if (frm_err) frm_cycles++;
        if (int'(rx_num_available) > max_cnt) max_cnt = int'(rx_num_available);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; optionally a pop is aligned with the STOP sampling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input logic pop_at_stop, input logic [7:0] pop_exp);
        int bp;
        int pc;
        bp = int'({DBH, DBL}) + 1;
        pc = int'({DBH, DBL} >> 1) + 3;
        RX = 1'b0;
        step(bp);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            step(bp);
        end
        RX = stop_val;
        for (int c = 0; c < bp; c++) begin
            if (pop_at_stop && c == pc) begin
                iocs_n = 1'b0;
                chk("coincident_pop_data", 32'(rx_data), 32'(pop_exp));
            end
            step(1);
            iocs_n = 1'b1;
        end
        RX = 1'b1;
    endtask

    task automatic pop_byte(input logic [7:0] exp, input string tag);
        iocs_n = 1'b0;
        iorw_n = 1'b1;
        ioaddr = 2'b00;
        chk(tag, 32'(rx_data), 32'(exp));
        step(1);
        iocs_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ovr_cycles = 0;
        frm_cycles = 0;
        max_cnt    = 0;
        rst    = 1'b1;
        RX     = 1'b1;
        iocs_n = 1'b1;
        iorw_n = 1'b1;
        ioaddr = 2'b00;
        DBH    = 5'd0;
        DBL    = 8'd15;

        // Reset values
        step(3);
        chk("rst_empty", 32'(rx_queue_empty), 32'd1);
        chk("rst_full", 32'(rx_queue_full), 32'd0);
        chk("rst_count", 32'(rx_num_available), 32'd0);
        chk("rst_overrun", 32'(rx_overrun), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        step(5);

        // Single frame 0x55
        send_frame(8'h55, 1'b1, 1'b0, 8'h00);
        chk("f55_data", 32'(rx_data), 32'h55);
        chk("f55_count", 32'(rx_num_available), 32'd1);
        chk("f55_empty", 32'(rx_queue_empty), 32'd0);
        pop_byte(8'h55, "f55_pop");
        chk("f55_count_after_pop", 32'(rx_num_available), 32'd0);
        chk("f55_empty_after_pop", 32'(rx_queue_empty), 32'd1);

        // Fill queue back-to-back, then overrun
        ovr_cycles = 0;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0, 8'h00);
        chk("fill_full", 32'(rx_queue_full), 32'd1);
        chk("fill_count", 32'(rx_num_available), 32'd8);
        chk("fill_no_overrun", 32'(ovr_cycles), 32'd0);
        send_frame(8'hAA, 1'b1, 1'b0, 8'h00);
        chk("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
        chk("ovr_count", 32'(rx_num_available), 32'd8);
        for (int i = 1; i <= 8; i++) pop_byte(8'(i), "drain_order");
        chk("drain_empty", 32'(rx_queue_empty), 32'd1);

        // Framing error, then a good frame
        frm_cycles = 0;
        ovr_cycles = 0;
        send_frame(8'h3C, 1'b0, 1'b0, 8'h00);
        RX = 1'b1;
        step(20);
        chk("frm_pulse_cycles", 32'(frm_cycles), 32'd1);
        chk("frm_count", 32'(rx_num_available), 32'd0);
        chk("frm_no_overrun", 32'(ovr_cycles), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0, 8'h00);
        chk("after_frm_count", 32'(rx_num_available), 32'd1);
        pop_byte(8'hC3, "after_frm_data");

        // Short low glitch is rejected in START
        frm_cycles = 0;
        RX = 1'b0;
        step(4);
        RX = 1'b1;
        step(40);
        chk("glitch_count", 32'(rx_num_available), 32'd0);
        chk("glitch_no_frm", 32'(frm_cycles), 32'd0);
        chk("glitch_no_ovr", 32'(ovr_cycles), 32'd0);

        // Pointer wrap: 20 receive/pop pairs
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1, 1'b0, 8'h00);
            pop_byte(8'h40 + 8'(i), "wrap_data");
        end
        chk("wrap_max_count", 32'(max_cnt), 32'd1);
        chk("wrap_empty", 32'(rx_queue_empty), 32'd1);

        // Faster divisor D=7
        DBL = 8'd7;
        send_frame(8'h5A, 1'b1, 1'b0, 8'h00);
        chk("d7_count", 32'(rx_num_available), 32'd1);
        pop_byte(8'h5A, "d7_data");
        DBL = 8'd15;
        step(5);

        // Full queue with a pop on the STOP tick of a new frame
        for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0, 8'h00);
        chk("coinc_full_before", 32'(rx_num_available), 32'd8);
        ovr_cycles = 0;
        send_frame(8'h77, 1'b1, 1'b1, 8'h21);
        chk("coinc_ovr_cycles", 32'(ovr_cycles), 32'd1);
        chk("coinc_count", 32'(rx_num_available), 32'd7);
        chk("coinc_not_full", 32'(rx_queue_full), 32'd0);
        for (int i = 1; i < 8; i++) pop_byte(8'h21 + 8'(i), "coinc_drain");
        chk("coinc_drain_empty", 32'(rx_queue_empty), 32'd1);

        // Reset mid-DATA aborts the frame and empties the queue
        send_frame(8'h11, 1'b1, 1'b0, 8'h00);
        chk("pre_rst_count", 32'(rx_num_available), 32'd1);
        RX = 1'b0;
        step(46);
        rst = 1'b1;
        #1;
        chk("midrst_empty", 32'(rx_queue_empty), 32'd1);
        chk("midrst_full", 32'(rx_queue_full), 32'd0);
        chk("midrst_count", 32'(rx_num_available), 32'd0);
        chk("midrst_overrun", 32'(rx_overrun), 32'd0);
        chk("midrst_frm_err", 32'(frm_err), 32'd0);
        step(2);
        RX = 1'b1;
        rst = 1'b0;
        frm_cycles = 0;
        step(40);
        chk("post_rst_count", 32'(rx_num_available), 32'd0);
        chk("post_rst_no_frm", 32'(frm_cycles), 32'd0);
        send_frame(8'h96, 1'b1, 1'b0, 8'h00);
        chk("post_rst_frame_count", 32'(rx_num_available), 32'd1);
        pop_byte(8'h96, "post_rst_frame_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_queue.md
# uart_rx_queue

UART receive path for the memory-mapped UART peripheral: deserialises 8N1 frames from the RX pin at a software-programmed baud divisor and pushes each good byte into an 8-entry circular queue. The processor pops bytes through the shared I/O bus, and the block exports queue occupancy and status.

## Interface
- No parameters. Queue depth is fixed at 8, data width at 8, and the divisor at 13 bits.
- clk  input  1  system clock. One clock; reset is asynchronous and active-high.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial input. Asynchronous to clk; idles high.
- iocs_n  input  1  I/O chip select, active low.
- iorw_n  input  1  1 = read, 0 = write.
- ioaddr  input  2  I/O register address. 2'b00 is the data register.
- DBH  input  5  baud divisor, high bits.
- DBL  input  8  baud divisor, low bits. D = {DBH,DBL}.
- rx_data  output  8  head-of-queue byte (combinational from the queue).
- rx_queue_empty  output  1  1 when the queue holds 0 entries.
- rx_queue_full  output  1  1 when the queue holds 8 entries.
- rx_num_available  output  4  number of entries held, 0..8.
- rx_overrun  output  1  one-cycle pulse when a good byte is dropped because the queue is full.
- frm_err  output  1  one-cycle pulse when the stop bit is sampled low. The byte is discarded.

## Operation
- RX passes through a 2-flop synchroniser (rx_sync). The synchroniser flops reset to 1.
- Baud counter baud_cnt, 13 bits, counts down. A "tick" occurs when baud_cnt==0.
  - Reloading with D gives a bit period of D+1 cycles.
  - Reloading with D>>1 gives a half period of (D>>1)+1 cycles.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_sync==0, load baud_cnt = D>>1 and go to START. Otherwise hold; baud_cnt does not count.
  - START: on tick, if rx_sync==0, load D, clear bit_cnt and go to DATA. If rx_sync==1 it is a false start: go to IDLE and push nothing.
  - DATA: on each tick, shift_reg <= {rx_sync, shift_reg[7:1]} (LSB first), reload D and increment bit_cnt. On the tick that makes bit_cnt==8, reload D and go to STOP.
  - STOP: on tick, if rx_sync==1 push shift_reg, or pulse rx_overrun if the queue is full. If rx_sync==0, pulse frm_err. Go to IDLE in every case. IDLE rearms immediately, so back-to-back frames are accepted.
- D is sampled at each load. A divisor change mid-frame takes effect at the next reload.
- Queue: 8 x 8 storage with 4-bit write_ptr and read_ptr. Entries are indexed by ptr[2:0].
  - rx_num_available = write_ptr - read_ptr (4-bit wrap arithmetic).
  - full = (count==8); empty = (count==0).
- Pop: when iocs_n==0, iorw_n==1, ioaddr==2'b00 and the queue is not empty, read_ptr increments at the clock edge. A pop on an empty queue is ignored; rx_data is then don't-care.
- rx_data = queue[read_ptr[2:0]]. It is valid during the read cycle, so the CPU samples the byte and pops in the same bus cycle.
- Writes and other ioaddr values are ignored by this block.
- Simultaneous push and pop:
  - Not full: both occur and the count is unchanged.
  - Full: fullness is evaluated before the pop, so the push is dropped (rx_overrun pulses) and the pop still occurs.
- Pointers wrap mod 16 with no special handling; the index wraps mod 8.

## Timing
- Reset values:
  - state IDLE; baud_cnt 0; bit_cnt 0; shift_reg 8'h00; pointers 0.
  - rx_queue_empty 1; rx_queue_full 0; rx_num_available 0; rx_overrun 0; frm_err 0; rx_data don't-care (storage is not reset).
- Reset asserted mid-frame aborts the frame: the FSM returns to IDLE and the queue is emptied.
- RX to FSM latency is 2 cycles (synchroniser).
- Start-bit mid-sample occurs (D>>1)+1 cycles after the FSM sees the falling edge. Each following sample is D+1 cycles later.
- Push edge is the STOP tick. On the next cycle: count increments, rx_queue_empty falls and rx_data is valid if the queue was previously empty.
- rx_overrun and frm_err are registered, high for exactly the cycle after the STOP tick.

## Test plan
- Reset, then D=15 (16 cycles/bit); drive frame 0x55 on RX -> one push; rx_data=8'h55, rx_num_available=1, rx_queue_empty=0; a pop cycle returns count 0 and rx_queue_empty=1.
- Eight back-to-back frames 0x01..0x08, no pops -> rx_queue_full=1, count=8. A ninth frame 0xAA -> rx_overrun pulses for one cycle and count stays 8. Then 8 pops return 0x01..0x08 in order.
- Frame 0x3C with stop bit driven 0 -> frm_err pulses once, no push, count unchanged. The next good frame 0xC3 is received correctly.
- RX low glitch of 4 cycles with D=15 -> START rejects it and returns to IDLE; no push and no error pulses.
- Pointer wrap: 20 receive/pop pairs with incrementing data -> each popped byte matches the byte sent, count never exceeds 1, and ptr[3] wraps cleanly.
- Queue full with a pop coinciding with the STOP tick of a new frame -> push dropped, rx_overrun pulses and count goes 8 -> 7. Separately, rst asserted mid-DATA -> all outputs return to their reset values and the next frame is received correctly.
